// File: rtl/led_blink_gen_if.sv
// Blink-phase bundle: phase restart request in, tick and blink waveforms out.
// slave = generator side, master = consumer / pattern decoder side.
interface led_blink_gen_if;
  logic phase_clr;
  logic tick_1ms;
  logic clk_1hz;
  logic clk_2hz;
  logic clk_4hz;
  logic clk_4hz_500ms;
  logic clk_4hz_3500ms;
  logic clk_07s;

  modport master (
    output phase_clr,
    input  tick_1ms,
    input  clk_1hz,
    input  clk_2hz,
    input  clk_4hz,
    input  clk_4hz_500ms,
    input  clk_4hz_3500ms,
    input  clk_07s
  );

  modport slave (
    input  phase_clr,
    output tick_1ms,
    output clk_1hz,
    output clk_2hz,
    output clk_4hz,
    output clk_4hz_500ms,
    output clk_4hz_3500ms,
    output clk_07s
  );
endinterface

// File: rtl/led_blink_gen.sv
// Phase-locked LED blink waveforms from one free-running 1 ms timebase.
// Ports: sysclk, reset_n (async low), bus (slave: phase_clr in;
// tick_1ms and clk_* out). Macro LED_BLINK_FAST_SIM_EN forces DIV=4.
module led_blink_gen #(
  parameter int SYSCLK_HZ = 25000000
) (
  input logic      sysclk,
  input logic      reset_n,
  led_blink_gen_if.slave bus
);

`ifdef LED_BLINK_FAST_SIM_EN
  localparam int DIV = 4;
`else
  localparam int DIV = SYSCLK_HZ / 1000;
`endif
  localparam int PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0] PS_MAX =
    PS_W'(DIV - 1);

  // The 4 s frame is kept as ms = 125*q + sub,
  // so every modulo decode is a single bit of q.
  logic [PS_W-1:0] ps, ps_nxt;
  logic [6:0]      sub, sub_nxt;
  logic [4:0]      q, q_nxt;
  logic [10:0]     c7, c7_nxt;
  logic            tick_nxt, wrap;

  logic            tick_q;
  logic            c1_q, c2_q, c4_q;
  logic            b500_q, b3500_q, c07_q;
  logic            c4_d, early_d;

  always_comb begin
    wrap     = (ps == PS_MAX);
    ps_nxt   = ps + PS_W'(1);
    sub_nxt  = sub;
    q_nxt    = q;
    c7_nxt   = c7;
    tick_nxt = 1'b0;
    if (bus.phase_clr) begin
      ps_nxt  = '0;
      sub_nxt = '0;
      q_nxt   = '0;
      c7_nxt  = '0;
    end else if (wrap) begin
      ps_nxt   = '0;
      tick_nxt = 1'b1;
      c7_nxt   = (c7 == 11'd1399) ?
                 11'd0 : c7 + 11'd1;
      if (sub == 7'd124) begin
        sub_nxt = '0;
        q_nxt   = q + 5'd1;
      end else begin
        sub_nxt = sub + 7'd1;
      end
    end
  end

  // Outputs decode the value the counters are
  // about to hold, so each clk_* edge lands on
  // the same edge as its tick_1ms pulse.
  always_comb begin
    c4_d    = ~q_nxt[0];
    early_d = (q_nxt[4:2] == 3'd0);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      ps      <= '0;
      sub     <= '0;
      q       <= '0;
      c7      <= '0;
      tick_q  <= 1'b0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      c4_q    <= 1'b0;
      b500_q  <= 1'b0;
      b3500_q <= 1'b0;
      c07_q   <= 1'b0;
    end else begin
      ps      <= ps_nxt;
      sub     <= sub_nxt;
      q       <= q_nxt;
      c7      <= c7_nxt;
      tick_q  <= tick_nxt;
      c1_q    <= ~q_nxt[2];
      c2_q    <= ~q_nxt[1];
      c4_q    <= c4_d;
      b500_q  <= c4_d & early_d;
      b3500_q <= c4_d & ~early_d;
      c07_q   <= (c7_nxt < 11'd700);
    end
  end

  assign bus.tick_1ms       = tick_q;
  assign bus.clk_1hz        = c1_q;
  assign bus.clk_2hz        = c2_q;
  assign bus.clk_4hz        = c4_q;
  assign bus.clk_4hz_500ms  = b500_q;
  assign bus.clk_4hz_3500ms = b3500_q;
  assign bus.clk_07s        = c07_q;

endmodule
